// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the register file / rename table and its read ports.
// Optional commit-to-operand forwarding is enabled with `define REG_BYPASS_EN.
package reg_rename_file_pkg;

    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_TAG_W    = 4;
    localparam int unsigned DEF_NUM_RD   = 2;

    // Architectural x0 and the tag value held by a never-renamed register
    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned EMPTY_TAG = 0;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One source-operand read port: x0 override and, with REG_BYPASS_EN, commit forwarding.
module reg_read_port
    import reg_rename_file_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              ent_busy,
    input  logic [TAG_W-1:0]  ent_tag,
    input  logic [XLEN-1:0]   ent_value,
`ifdef REG_BYPASS_EN
    input  logic              cm_fwd,
    input  logic [TAG_W-1:0]  cm_tag,
    input  logic [XLEN-1:0]   cm_value,
`endif
    output logic              busy,
    output logic [TAG_W-1:0]  tag,
    output logic [XLEN-1:0]   value
);

    always_comb begin
        busy  = ent_busy;
        tag   = ent_tag;
        value = ent_value;
`ifdef REG_BYPASS_EN
        // The producing ROB entry is committing right now: take its result directly
        if (ent_busy && cm_fwd && (ent_tag == cm_tag)) begin
            busy  = 1'b0;
            value = cm_value;
        end
`endif
        if (addr == ADDR_W'(REG_ZERO)) begin
            busy  = 1'b0;
            tag   = '0;
            value = '0;
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename tag table with NUM_RD combinational read ports.
// Optional commit-to-operand forwarding is enabled with `define REG_BYPASS_EN.
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned XLEN     = DEF_XLEN,
    parameter  int unsigned TAG_W    = DEF_TAG_W,
    parameter  int unsigned NUM_RD   = DEF_NUM_RD,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
    localparam int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    output logic [NUM_RD*XLEN-1:0]   rd_value,
    input  logic                     al_valid,
    input  logic [ADDR_W-1:0]        al_addr,
    input  logic [TAG_W-1:0]         al_tag,
    input  logic                     cm_valid,
    input  logic [ADDR_W-1:0]        cm_addr,
    input  logic [TAG_W-1:0]         cm_tag,
    input  logic [XLEN-1:0]          cm_value,
    output logic [CNT_W-1:0]         busy_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic [TAG_W-1:0]    tags   [NUM_REGS];
    logic [XLEN-1:0]     values [NUM_REGS];

    logic al_go;
    logic cm_go;
    logic al_set;
    logic cm_clear;

    // Effective alloc/commit; a commit only releases when no younger renamer took the register
    always_comb begin
        al_go    = al_valid && rdy && !clr && (al_addr != ADDR_W'(REG_ZERO));
        cm_go    = cm_valid && rdy && (cm_addr != ADDR_W'(REG_ZERO));
        al_set   = al_go && !busy[al_addr];
        cm_clear = cm_go && busy[cm_addr] && (tags[cm_addr] == cm_tag)
                   && !(al_go && (al_addr == cm_addr));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                values[i] <= '0;
            end
        end else if (cm_go) begin
            values[cm_addr] <= cm_value;
        end
    end

    // Busy bits, tags and the busy counter; clr drops pending renames but keeps tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                tags[i] <= TAG_W'(EMPTY_TAG);
            end
        end else if (clr) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (cm_clear) begin
                busy[cm_addr] <= 1'b0;
            end
            if (al_go) begin
                busy[al_addr] <= 1'b1;
                tags[al_addr] <= al_tag;
            end
            busy_cnt <= busy_cnt + CNT_W'(al_set) - CNT_W'(cm_clear);
        end
    end

`ifdef REG_BYPASS_EN
    logic cm_fwd;
    assign cm_fwd = cm_valid && rdy;
`endif

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        reg_read_port #(
            .XLEN   (XLEN),
            .TAG_W  (TAG_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .addr      (ra),
            .ent_busy  (busy[ra]),
            .ent_tag   (tags[ra]),
            .ent_value (values[ra]),
`ifdef REG_BYPASS_EN
            .cm_fwd    (cm_fwd),
            .cm_tag    (cm_tag),
            .cm_value  (cm_value),
`endif
            .busy      (rd_busy[i]),
            .tag       (rd_tag[i*TAG_W +: TAG_W]),
            .value     (rd_value[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios plus randomized traffic vs. a model.
module tb_reg_rename_file;

    localparam int unsigned NR = 32;
    localparam int unsigned XL = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned RD = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             clr;
    logic [RD*AW-1:0] rd_addr;
    logic [RD-1:0]    rd_busy;
    logic [RD*TW-1:0] rd_tag;
    logic [RD*XL-1:0] rd_value;
    logic             al_valid;
    logic [AW-1:0]    al_addr;
    logic [TW-1:0]    al_tag;
    logic             cm_valid;
    logic [AW-1:0]    cm_addr;
    logic [TW-1:0]    cm_tag;
    logic [XL-1:0]    cm_value;
    logic [CW-1:0]    busy_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: what each architectural register holds right now
    logic [XL-1:0] m_val  [NR];
    bit            m_busy [NR];
    logic [TW-1:0] m_tag  [NR];

    reg_rename_file #(.NUM_REGS(NR), .XLEN(XL), .TAG_W(TW), .NUM_RD(RD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_value(rd_value),
        .al_valid(al_valid), .al_addr(al_addr), .al_tag(al_tag),
        .cm_valid(cm_valid), .cm_addr(cm_addr), .cm_tag(cm_tag), .cm_value(cm_value),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < int'(NR); i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic model_check();
        for (int p = 0; p < int'(RD); p++) begin
            int            a;
            bit            eb;
            logic [TW-1:0] et;
            logic [XL-1:0] ev;
            a  = int'(rd_addr[p*AW +: AW]);
            eb = (a != 0) && m_busy[a];
            et = (a != 0) ? m_tag[a] : '0;
            ev = (a != 0) ? m_val[a] : '0;
`ifdef REG_BYPASS_EN
            if (eb && cm_valid && rdy && (et == cm_tag)) begin
                eb = 1'b0;
                ev = cm_value;
            end
`endif
            chk($sformatf("model rd_busy[%0d] x%0d", p, a), 32'(rd_busy[p]), 32'(eb));
            if (eb) chk($sformatf("model rd_tag[%0d] x%0d", p, a), 32'(rd_tag[p*TW +: TW]), 32'(et));
            else    chk($sformatf("model rd_value[%0d] x%0d", p, a), rd_value[p*XL +: XL], ev);
        end
        chk("model busy_cnt", 32'(busy_cnt), 32'(model_count()));
    endtask

    // Apply the update the coming clock edge will perform
    task automatic model_step();
        int ca = int'(cm_addr);
        int aa = int'(al_addr);
        bit release_hit = 1'b0;
        if (rdy && cm_valid && ca != 0) begin
            m_val[ca]   = cm_value;
            release_hit = m_busy[ca] && (m_tag[ca] == cm_tag);
        end
        if (release_hit) m_busy[ca] = 1'b0;
        if (rdy && al_valid && !clr && aa != 0) begin
            m_busy[aa] = 1'b1;
            m_tag[aa]  = al_tag;
        end
        if (clr) for (int i = 0; i < int'(NR); i++) m_busy[i] = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            model_check();
            if (rst) model_step();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        al_valid = 1'b0;
        cm_valid = 1'b0;
        clr      = 1'b0;
        rdy      = 1'b1;
    endtask

    task automatic alloc(input int a, input int t);
        al_valid = 1'b1;
        al_addr  = AW'(a);
        al_tag   = TW'(t);
    endtask

    task automatic commit(input int a, input int t, input logic [31:0] v);
        cm_valid = 1'b1;
        cm_addr  = AW'(a);
        cm_tag   = TW'(t);
        cm_value = v;
    endtask

    task automatic set_rd(input int a0, input int a1);
        logic [AW-1:0] x0;
        logic [AW-1:0] x1;
        x0 = AW'(a0);
        x1 = AW'(a1);
        rd_addr = {x1, x0};
    endtask

    initial begin
        rst = 1'b0;
        idle();
        al_addr = '0; al_tag = '0; cm_addr = '0; cm_tag = '0; cm_value = '0;
        set_rd(0, 0);
        #1;
        chk("reset busy_cnt", 32'(busy_cnt), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Alloc then commit the same tag
        alloc(5, 3); step(); idle();
        set_rd(5, 0); #1;
        chk("x5 busy after alloc", 32'(rd_busy[0]), 32'd1);
        chk("x5 tag after alloc", 32'(rd_tag[TW-1:0]), 32'd3);
        chk("busy_cnt after x5 alloc", 32'(busy_cnt), 32'd1);
        commit(5, 3, 32'hDEADBEEF); step(); idle(); #1;
        chk("x5 busy after commit", 32'(rd_busy[0]), 32'd0);
        chk("x5 value after commit", rd_value[XL-1:0], 32'hDEADBEEF);
        chk("busy_cnt after x5 commit", 32'(busy_cnt), 32'd0);

        // Older commit must not release a younger rename
        alloc(7, 2); step();
        alloc(7, 9); step(); idle();
        commit(7, 2, 32'h11); step(); idle();
        set_rd(7, 5); #1;
        chk("x7 stays busy", 32'(rd_busy[0]), 32'd1);
        chk("x7 young tag", 32'(rd_tag[TW-1:0]), 32'd9);
        chk("x7 value written", rd_value[XL-1:0], 32'h11);
        chk("busy_cnt after x7", 32'(busy_cnt), 32'd1);

        // Same-cycle alloc and commit to one register: alloc wins
        alloc(4, 1); step(); idle();
        alloc(4, 6); commit(4, 1, 32'h22); step(); idle();
        set_rd(4, 7); #1;
        chk("x4 busy", 32'(rd_busy[0]), 32'd1);
        chk("x4 new tag", 32'(rd_tag[TW-1:0]), 32'd6);
        chk("x4 value", rd_value[XL-1:0], 32'h22);
        chk("busy_cnt after x4", 32'(busy_cnt), 32'd2);

        // Asynchronous reset mid-run with busy registers
        set_rd(7, 5); #1;
        rst = 1'b0; #1;
        chk("async reset busy_cnt", 32'(busy_cnt), 32'd0);
        chk("async reset x7 busy", 32'(rd_busy[0]), 32'd0);
        chk("async reset x5 value", rd_value[2*XL-1:XL], 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Flush drops pending renames and the same-cycle alloc
        alloc(1, 1); step();
        alloc(2, 2); step();
        alloc(3, 3); step(); idle(); #1;
        chk("busy_cnt before clr", 32'(busy_cnt), 32'd3);
        clr = 1'b1; alloc(8, 5); step(); idle();
        set_rd(8, 1); #1;
        chk("x8 not busy after clr", 32'(rd_busy[0]), 32'd0);
        chk("x1 not busy after clr", 32'(rd_busy[1]), 32'd0);
        chk("busy_cnt after clr", 32'(busy_cnt), 32'd0);
        alloc(0, 3); commit(0, 3, 32'h55); set_rd(0, 0); #1;
        chk("x0 busy during access", 32'(rd_busy[0]), 32'd0);
        step(); idle(); #1;
        chk("x0 busy", 32'(rd_busy[0]), 32'd0);
        chk("x0 value", rd_value[XL-1:0], 32'd0);
        chk("busy_cnt after x0", 32'(busy_cnt), 32'd0);

        // rdy low freezes alloc and commit
        alloc(9, 4); step(); idle();
        rdy = 1'b0; alloc(10, 7); commit(9, 4, 32'h44); step(); idle();
        set_rd(9, 10); #1;
        chk("x9 still busy when frozen", 32'(rd_busy[0]), 32'd1);
        chk("x9 tag when frozen", 32'(rd_tag[TW-1:0]), 32'd4);
        chk("x10 not allocated when frozen", 32'(rd_busy[1]), 32'd0);
        chk("busy_cnt when frozen", 32'(busy_cnt), 32'd1);
`ifdef REG_BYPASS_EN
        commit(9, 4, 32'h33); #1;
        chk("bypass x9 busy", 32'(rd_busy[0]), 32'd0);
        chk("bypass x9 value", rd_value[XL-1:0], 32'h33);
        step(); idle(); #1;
        chk("x9 committed value", rd_value[XL-1:0], 32'h33);
`endif

        // Randomized traffic, biased toward a few registers to force collisions
        for (int n = 0; n < 3000; n++) begin
            int a;
            int c;
            a = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NR - 1, 0)) : int'($urandom_range(7, 0));
            c = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NR - 1, 0)) : int'($urandom_range(7, 0));
            rdy      = ($urandom_range(9, 0) != 0);
            clr      = ($urandom_range(39, 0) == 0);
            al_valid = $urandom_range(1, 0) == 1;
            al_addr  = AW'(a);
            al_tag   = TW'($urandom);
            cm_valid = $urandom_range(1, 0) == 1;
            cm_addr  = AW'(c);
            cm_tag   = ($urandom_range(2, 0) != 0) ? m_tag[c] : TW'($urandom);
            cm_value = $urandom;
            case ($urandom_range(3, 0))
                0:       set_rd(a, c);
                1:       set_rd(c, int'($urandom_range(7, 0)));
                default: set_rd(int'($urandom_range(NR - 1, 0)), int'($urandom_range(7, 0)));
            endcase
            step();
        end
        idle();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
